// File: rtl/lutram_fifo32_if.sv
// lutram_fifo32_if: producer/consumer bus of lutram_fifo32
// Signals: WR_EN/WR_DATA push, FULL/ALMOST_FULL/OVF status,
//          RD_VALID/RD_READY/RD_DATA head handshake, LEVEL total occupancy.
// master = the side that pushes and pops, slave = the FIFO.
interface lutram_fifo32_if #(
  parameter int WIDTH = 8
);
  logic             WR_EN;
  logic [WIDTH-1:0] WR_DATA;
  logic             FULL;
  logic             ALMOST_FULL;
  logic             OVF;
  logic             RD_VALID;
  logic             RD_READY;
  logic [WIDTH-1:0] RD_DATA;
  logic [5:0]       LEVEL;
  modport master (
    output WR_EN, WR_DATA, RD_READY,
    input  FULL, ALMOST_FULL, OVF, RD_VALID, RD_DATA, LEVEL
  );
  modport slave (
    input  WR_EN, WR_DATA, RD_READY,
    output FULL, ALMOST_FULL, OVF, RD_VALID, RD_DATA, LEVEL
  );
endinterface

// File: rtl/lutram_fifo32.sv
// lutram_fifo32: 32-deep LUTRAM FIFO with a registered first-word-fall-through output stage
// Ports: CLK clock; RST_N asynchronous active-low reset;
//        bus (slave) carries push (WR_EN, WR_DATA), status (FULL, ALMOST_FULL, OVF, LEVEL)
//        and the valid/ready head of queue (RD_VALID, RD_READY, RD_DATA).
module lutram_fifo32 #(
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = 28
) (
  input logic            CLK,
  input logic            RST_N,
  lutram_fifo32_if.slave bus
);
  logic [4:0]       wptr;
  logic [4:0]       rptr;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] ram_q;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             ovf;
  logic             full;
  logic             push;
  logic             load;
  assign full = cnt == 6'd32;
  assign push = bus.WR_EN && !full;
  // the output register refills whenever it is empty or being consumed
  assign load = cnt != 6'd0 && (!rd_valid || bus.RD_READY);
  // WIDTH parallel 32x1 dual-port slices: write port at wptr, async read port at rptr
  for (genvar b = 0; b < WIDTH; b++) begin : g_slice
    logic [31:0] slice;
    always_ff @(posedge CLK)
      if (push) slice[wptr] <= bus.WR_DATA[b];
    assign ram_q[b] = slice[rptr];
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      ovf      <= 1'b0;
    end else begin
      wptr     <= push ? wptr + 5'd1 : wptr;
      rptr     <= load ? rptr + 5'd1 : rptr;
      cnt      <= cnt + 6'(push) - 6'(load);
      rd_valid <= load || (rd_valid && !bus.RD_READY);
      rd_data  <= load ? ram_q : rd_data;
      ovf      <= bus.WR_EN && full;
    end
  assign bus.FULL        = full;
  assign bus.ALMOST_FULL = cnt >= 6'(AF_LEVEL);
  assign bus.OVF         = ovf;
  assign bus.RD_VALID    = rd_valid;
  assign bus.RD_DATA     = rd_data;
  assign bus.LEVEL       = cnt + 6'(rd_valid);
endmodule

// File: tb/tb_lutram_fifo32.sv
// tb_lutram_fifo32: randomized and directed checks of lutram_fifo32 against a queue model
module tb_lutram_fifo32;
  localparam int AF = 28;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails = 0;
  logic [7:0] mq[$];
  bit   m_valid = 1'b0;
  bit   m_ovf = 1'b0;
  lutram_fifo32_if #(.WIDTH(8)) bus ();
  lutram_fifo32 #(.WIDTH(8), .AF_LEVEL(AF)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic int m_cnt();
    return mq.size() - int'(m_valid);
  endfunction
  // advance one edge and update the model from the inputs seen at that edge
  task automatic tick();
    int  c;
    c = m_cnt();
    m_ovf = bus.WR_EN && c == 32;
    if (m_valid && bus.RD_READY) void'(mq.pop_front());
    m_valid = mq.size() > 0;
    if (bus.WR_EN && c < 32) mq.push_back(bus.WR_DATA);
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    checks++; if (bus.LEVEL !== 6'd0 || bus.RD_VALID !== 1'b0 || bus.FULL !== 1'b0 || bus.ALMOST_FULL !== 1'b0 || bus.OVF !== 1'b0) begin fails++; $display("FAIL reset_por: level=%0d valid=%b full=%b af=%b ovf=%b, want all 0", bus.LEVEL, bus.RD_VALID, bus.FULL, bus.ALMOST_FULL, bus.OVF); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.WR_EN = 1'b1; bus.WR_DATA = 8'(i + 8'h30); tick();
    end
    bus.WR_EN = 1'b0;
    checks++; if (bus.LEVEL !== 6'(mq.size())) begin fails++; $display("FAIL reset_prefill_level: got %0d want %0d", bus.LEVEL, mq.size()); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.LEVEL !== 6'd0) begin fails++; $display("FAIL reset_async_level: got %0d want 0", bus.LEVEL); end
    checks++; if (bus.RD_VALID !== 1'b0) begin fails++; $display("FAIL reset_async_valid: got %b want 0", bus.RD_VALID); end
    checks++; if (bus.RD_DATA !== 8'h00) begin fails++; $display("FAIL reset_async_data: got %h want 00", bus.RD_DATA); end
    checks++; if (bus.FULL !== 1'b0) begin fails++; $display("FAIL reset_async_full: got %b want 0", bus.FULL); end
    mq.delete(); m_valid = 1'b0; m_ovf = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask
  task automatic test_latency();
    bus.RD_READY = 1'b0; bus.WR_EN = 1'b1; bus.WR_DATA = 8'hA5;
    tick();
    bus.WR_EN = 1'b0;
    checks++; if (bus.RD_VALID !== 1'b0 || bus.LEVEL !== 6'd1) begin fails++; $display("FAIL latency_edge_n: valid=%b level=%0d, want 0 and 1", bus.RD_VALID, bus.LEVEL); end
    tick();
    checks++; if (bus.RD_VALID !== 1'b1 || bus.RD_DATA !== 8'hA5) begin fails++; $display("FAIL latency_edge_n1: valid=%b data=%h, want 1 and a5", bus.RD_VALID, bus.RD_DATA); end
    checks++; if (bus.LEVEL !== 6'd1) begin fails++; $display("FAIL latency_level: got %0d want 1", bus.LEVEL); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (bus.RD_VALID !== 1'b1 || bus.RD_DATA !== 8'hA5) begin fails++; $display("FAIL latency_hold: valid=%b data=%h, want 1 and a5", bus.RD_VALID, bus.RD_DATA); end
    // drain the last word while pushing into an empty RAM
    bus.RD_READY = 1'b1; bus.WR_EN = 1'b1; bus.WR_DATA = 8'h5A;
    tick();
    bus.WR_EN = 1'b0;
    checks++; if (bus.RD_VALID !== 1'b0 || bus.LEVEL !== 6'd1) begin fails++; $display("FAIL drain_push: valid=%b level=%0d, want 0 and 1", bus.RD_VALID, bus.LEVEL); end
    tick();
    checks++; if (bus.RD_VALID !== 1'b1 || bus.RD_DATA !== 8'h5A) begin fails++; $display("FAIL drain_push_next: valid=%b data=%h, want 1 and 5a", bus.RD_VALID, bus.RD_DATA); end
    tick();
    checks++; if (bus.RD_VALID !== 1'b0 || bus.LEVEL !== 6'd0) begin fails++; $display("FAIL latency_empty: valid=%b level=%0d, want 0 and 0", bus.RD_VALID, bus.LEVEL); end
    bus.RD_READY = 1'b0;
  endtask
  task automatic test_fill_overflow();
    int ovf_seen = 0;
    int n = 0;
    bus.RD_READY = 1'b0;
    for (int i = 0; i < 34; i++) begin
      bus.WR_EN = 1'b1; bus.WR_DATA = 8'(i);
      tick();
      ovf_seen += int'(bus.OVF);
      checks++; if (bus.ALMOST_FULL !== (m_cnt() >= AF) || bus.FULL !== (m_cnt() == 32)) begin fails++; $display("FAIL fill_flags[%0d]: af=%b full=%b, cnt=%0d", i, bus.ALMOST_FULL, bus.FULL, m_cnt()); end
      if (i == 32) begin
        checks++; if (bus.FULL !== 1'b1 || bus.LEVEL !== 6'd33) begin fails++; $display("FAIL fill_33: full=%b level=%0d, want 1 and 33", bus.FULL, bus.LEVEL); end
      end
    end
    bus.WR_EN = 1'b0;
    tick();
    ovf_seen += int'(bus.OVF);
    checks++; if (ovf_seen != 1) begin fails++; $display("FAIL fill_ovf_pulses: got %0d want 1", ovf_seen); end
    bus.RD_READY = 1'b1;
    for (int k = 0; k < 40 && n < 33; k++) begin
      if (bus.RD_VALID) begin
        checks++; if (bus.RD_DATA !== 8'(n)) begin fails++; $display("FAIL fill_readout[%0d]: got %h want %h", n, bus.RD_DATA, 8'(n)); end
        n++;
      end
      tick();
    end
    checks++; if (n != 33 || bus.RD_VALID !== 1'b0 || bus.LEVEL !== 6'd0) begin fails++; $display("FAIL fill_readout_end: words=%0d valid=%b level=%0d, want 33 0 0", n, bus.RD_VALID, bus.LEVEL); end
    bus.RD_READY = 1'b0;
  endtask
  task automatic test_streaming();
    int  n = 0;
    bit  started = 1'b0;
    bus.RD_READY = 1'b1;
    for (int i = 0; i < 110 && n < 100; i++) begin
      bus.WR_EN = i < 100; bus.WR_DATA = 8'(i + 8'h40);
      tick();
      if (bus.RD_VALID) begin
        started = 1'b1;
        checks++; if (bus.RD_DATA !== 8'(n + 8'h40)) begin fails++; $display("FAIL stream_data[%0d]: got %h want %h", n, bus.RD_DATA, 8'(n + 8'h40)); end
        n++;
      end else if (started && n < 100) begin
        checks++; fails++; $display("FAIL stream_bubble: valid=0 after %0d words, want 1", n);
      end
    end
    bus.WR_EN = 1'b0;
    checks++; if (n != 100) begin fails++; $display("FAIL stream_count: got %0d want 100", n); end
    tick();
    checks++; if (bus.RD_VALID !== 1'b0 || bus.LEVEL !== 6'd0) begin fails++; $display("FAIL stream_empty: valid=%b level=%0d, want 0 0", bus.RD_VALID, bus.LEVEL); end
    bus.RD_READY = 1'b0;
  endtask
  task automatic test_backpressure();
    int  bad = 0;
    bit  hold;
    logic [7:0] hold_d;
    for (int i = 0; i < 10000; i++) begin
      bus.RD_READY = $urandom_range(1, 0) == 1;
      bus.WR_EN = $urandom_range(9, 0) < 7 && m_cnt() != 32;
      bus.WR_DATA = 8'($urandom);
      hold = m_valid && !bus.RD_READY;
      hold_d = m_valid ? mq[0] : 8'h00;
      tick();
      checks++;
      if (bus.RD_VALID !== m_valid || (m_valid && bus.RD_DATA !== mq[0]) || bus.LEVEL !== 6'(mq.size()) ||
          bus.FULL !== (m_cnt() == 32) || bus.ALMOST_FULL !== (m_cnt() >= AF) || bus.OVF !== 1'b0 ||
          (hold && bus.RD_DATA !== hold_d)) begin
        fails++;
        if (bad++ < 10) $display("FAIL bp[%0d]: valid=%b data=%h level=%0d full=%b af=%b ovf=%b, want valid=%b data=%h level=%0d cnt=%0d ovf=0", i, bus.RD_VALID, bus.RD_DATA, bus.LEVEL, bus.FULL, bus.ALMOST_FULL, bus.OVF, m_valid, m_valid ? mq[0] : 8'h00, mq.size(), m_cnt());
      end
    end
    bus.WR_EN = 1'b0;
  endtask
  task automatic test_full_boundary();
    bit seen_ee = 1'b0;
    bus.WR_EN = 1'b0; bus.RD_READY = 1'b1;
    for (int k = 0; k < 40 && mq.size() > 0; k++) tick();
    checks++; if (bus.LEVEL !== 6'd0) begin fails++; $display("FAIL fb_drain: level=%0d want 0", bus.LEVEL); end
    bus.RD_READY = 1'b0;
    for (int i = 0; i < 33; i++) begin
      bus.WR_EN = 1'b1; bus.WR_DATA = 8'(8'h80 + i); tick();
    end
    checks++; if (bus.FULL !== 1'b1 || bus.LEVEL !== 6'd33) begin fails++; $display("FAIL fb_full: full=%b level=%0d, want 1 33", bus.FULL, bus.LEVEL); end
    bus.RD_READY = 1'b1; bus.WR_EN = 1'b1; bus.WR_DATA = 8'hEE;
    tick();
    checks++; if (bus.OVF !== 1'b1 || bus.FULL !== 1'b0 || bus.LEVEL !== 6'd32) begin fails++; $display("FAIL fb_pop_push: ovf=%b full=%b level=%0d, want 1 0 32", bus.OVF, bus.FULL, bus.LEVEL); end
    bus.RD_READY = 1'b0; bus.WR_DATA = 8'h77;
    tick();
    bus.WR_EN = 1'b0;
    checks++; if (bus.OVF !== 1'b0 || bus.FULL !== 1'b1 || bus.LEVEL !== 6'd33) begin fails++; $display("FAIL fb_next_push: ovf=%b full=%b level=%0d, want 0 1 33", bus.OVF, bus.FULL, bus.LEVEL); end
    bus.RD_READY = 1'b1;
    for (int k = 0; k < 40 && mq.size() > 0; k++) begin
      checks++; if (bus.RD_VALID !== 1'b1 || bus.RD_DATA !== mq[0]) begin fails++; $display("FAIL fb_readout: valid=%b data=%h want 1 %h", bus.RD_VALID, bus.RD_DATA, mq[0]); end
      if (bus.RD_VALID && bus.RD_DATA === 8'hEE) seen_ee = 1'b1;
      if (mq.size() == 1) begin
        checks++; if (bus.RD_DATA !== 8'h77) begin fails++; $display("FAIL fb_last: got %h want 77", bus.RD_DATA); end
      end
      tick();
    end
    checks++; if (seen_ee || bus.LEVEL !== 6'd0) begin fails++; $display("FAIL fb_dropped: dropped word seen=%b level=%0d, want 0 0", seen_ee, bus.LEVEL); end
    bus.RD_READY = 1'b0;
  endtask
  initial begin
    bus.WR_EN = 1'b0; bus.WR_DATA = 8'h00; bus.RD_READY = 1'b0;
    #1;
    test_reset();
    test_latency();
    test_fill_overflow();
    test_streaming();
    test_backpressure();
    test_full_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
